// File: rtl/bcd_scan_sequencer.sv
// Shares one external combinational BCD converter across the seconds,
// minutes and hours counters, commits the six resulting digits atomically
// to display registers, and scans them onto a multiplexed 7-segment bus.
module bcd_scan_sequencer #(
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_HTENS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [5:0] hr,
  output logic [5:0] conv_bin,
  input  logic [3:0] conv_ones,
  input  logic [3:0] conv_tens,
  output logic       busy,
  output logic       upd_done,
  output logic [5:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       blank
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV_S = 2'd1;
  localparam logic [1:0] CONV_M = 2'd2;
  localparam logic [1:0] CONV_H = 2'd3;

  localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [1:0]    r_state;
  logic          r_pending;
  logic [5:0]    r_snapSec;
  logic [5:0]    r_snapMin;
  logic [5:0]    r_snapHr;
  logic [7:0]    r_shadowSec;
  logic [7:0]    r_shadowMin;
  logic [23:0]   r_disp;
  logic          r_updDone;
  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [5:0]    r_digitSel;
  logic [3:0]    r_digitVal;
  logic          r_blank;

  logic [7:0]    w_convDigits;
  logic          w_commit;
  logic          w_snapNow;
  logic [23:0]   w_dispNext;
  logic          w_scanWrap;
  logic [2:0]    w_idxNext;
  logic [3:0]    w_valNext;
  logic          w_blankNext;

  assign w_convDigits = {conv_tens, conv_ones};
  assign w_commit     = (r_state == CONV_H);
  assign w_snapNow    = ((r_state == IDLE) && tick) ||
                        ((r_state == CONV_H) && (r_pending || tick));
  // Display layout, low nibble first: sec ones/tens, min ones/tens, hr ones/tens
  assign w_dispNext   = w_commit ? {w_convDigits, r_shadowMin, r_shadowSec} : r_disp;
  assign w_scanWrap   = (r_presc == PRESC_LAST);

  assign busy      = (r_state != IDLE);
  assign upd_done  = r_updDone;
  assign digit_sel = r_digitSel;
  assign digit_val = r_digitVal;
  assign blank     = r_blank;

  // Operand for the shared converter follows the current conversion state
  always_comb begin
    conv_bin = 6'd0;
    case (r_state)
      CONV_S:  conv_bin = r_snapSec;
      CONV_M:  conv_bin = r_snapMin;
      CONV_H:  conv_bin = r_snapHr;
      default: conv_bin = 6'd0;
    endcase
  end

  // Conversion sequencer: snapshot, collect digits, chain a pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_snapSec   <= 6'd0;
      r_snapMin   <= 6'd0;
      r_snapHr    <= 6'd0;
      r_shadowSec <= 8'd0;
      r_shadowMin <= 8'd0;
      r_updDone   <= 1'b0;
    end else begin
      r_updDone <= w_commit;
      if (w_snapNow) begin
        r_snapSec <= sec;
        r_snapMin <= min;
        r_snapHr  <= hr;
      end
      case (r_state)
        IDLE: begin
          if (tick) r_state <= CONV_S;
        end
        CONV_S: begin
          r_shadowSec <= w_convDigits;
          r_state     <= CONV_M;
          if (tick) r_pending <= 1'b1;
        end
        CONV_M: begin
          r_shadowMin <= w_convDigits;
          r_state     <= CONV_H;
          if (tick) r_pending <= 1'b1;
        end
        default: begin
          r_pending <= 1'b0;
          r_state   <= (r_pending || tick) ? CONV_S : IDLE;
        end
      endcase
    end
  end

  // All six display digits change together at the hours capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_disp <= 24'd0;
    else if (w_commit) r_disp <= w_dispNext;
  end

  // Index the scan will show after this edge
  always_comb begin
    w_idxNext = r_idx;
    if (w_scanWrap) w_idxNext = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
  end

  // Digit value and blanking are looked up from the display contents after this edge
  always_comb begin
    w_valNext = 4'd0;
    case (w_idxNext)
      3'd0:    w_valNext = w_dispNext[3:0];
      3'd1:    w_valNext = w_dispNext[7:4];
      3'd2:    w_valNext = w_dispNext[11:8];
      3'd3:    w_valNext = w_dispNext[15:12];
      3'd4:    w_valNext = w_dispNext[19:16];
      3'd5:    w_valNext = w_dispNext[23:20];
      default: w_valNext = 4'd0;
    endcase
    w_blankNext = (BLANK_HTENS == 1) && (w_idxNext == 3'd5) && (w_dispNext[23:20] == 4'd0);
  end

  // Free-running digit scan, independent of the conversion sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_idx      <= 3'd0;
      r_digitSel <= 6'b000001;
      r_digitVal <= 4'd0;
      r_blank    <= 1'b0;
    end else begin
      r_presc    <= w_scanWrap ? '0 : r_presc + 1'b1;
      r_idx      <= w_idxNext;
      r_digitSel <= 6'b000001 << w_idxNext;
      r_digitVal <= w_valNext;
      r_blank    <= w_blankNext;
    end
  end

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// Directed self-checking bench for bcd_scan_sequencer: two instances with
// SCAN_DIV=4, one blanking the leading hours zero and one not.
module tb_bcd_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hr;

  logic [5:0] convBin;
  logic [3:0] convOnes;
  logic [3:0] convTens;
  logic       busy;
  logic       updDone;
  logic [5:0] digitSel;
  logic [3:0] digitVal;
  logic       blank;

  logic [5:0] conv2Bin;
  logic [3:0] conv2Ones;
  logic [3:0] conv2Tens;
  logic       busy2;
  logic       updDone2;
  logic [5:0] digitSel2;
  logic [3:0] digitVal2;
  logic       blank2;

  int testCount = 0;
  int failCount = 0;
  int cycleCount;
  int updCount = 0;
  int updStart;

  bcd_scan_sequencer #(.SCAN_DIV(4), .BLANK_HTENS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sec(sec), .min(min), .hr(hr),
    .conv_bin(convBin), .conv_ones(convOnes), .conv_tens(convTens),
    .busy(busy), .upd_done(updDone), .digit_sel(digitSel),
    .digit_val(digitVal), .blank(blank)
  );

  bcd_scan_sequencer #(.SCAN_DIV(4), .BLANK_HTENS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sec(sec), .min(min), .hr(hr),
    .conv_bin(conv2Bin), .conv_ones(conv2Ones), .conv_tens(conv2Tens),
    .busy(busy2), .upd_done(updDone2), .digit_sel(digitSel2),
    .digit_val(digitVal2), .blank(blank2)
  );

  // Behavioural model of the external combinational BCD converter
  assign convTens  = 4'(convBin / 6'd10);
  assign convOnes  = 4'(convBin % 6'd10);
  assign conv2Tens = 4'(conv2Bin / 6'd10);
  assign conv2Ones = 4'(conv2Bin % 6'd10);

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since the last reset release, used to predict scan position
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycleCount <= 0;
    else cycleCount <= cycleCount + 1;
  end

  // Count completed-update pulses away from the active edge
  always @(negedge clk) begin
    if (updDone) updCount <= updCount + 1;
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full update sequence with conv_bin/busy/upd_done checks per cycle
  task automatic applyStimulus(input logic [5:0] s, input logic [5:0] m, input logic [5:0] h);
    sec = s; min = m; hr = h; tick = 1'b1;
    nextCycle;
    tick = 1'b0;
    checkOutput("convSec", 32'(convBin), 32'(s));
    checkOutput("busyS", 32'(busy), 32'd1);
    nextCycle;
    checkOutput("convMin", 32'(convBin), 32'(m));
    checkOutput("busyM", 32'(busy), 32'd1);
    nextCycle;
    checkOutput("convHr", 32'(convBin), 32'(h));
    checkOutput("busyH", 32'(busy), 32'd1);
    checkOutput("updBefore", 32'(updDone), 32'd0);
    nextCycle;
    checkOutput("updDone", 32'(updDone), 32'd1);
    checkOutput("busyEnd", 32'(busy), 32'd0);
    checkOutput("convIdle", 32'(convBin), 32'd0);
    nextCycle;
    checkOutput("updOnce", 32'(updDone), 32'd0);
  endtask

  // Walk one full scan frame checking select, value and blanking on both instances
  task automatic scanCheck(input string tag, input logic [23:0] expDigits, input logic expBlank1, input logic expBlank2);
    int idx;
    logic [23:0] digits;
    digits = expDigits;
    for (int c = 0; c < 24; c++) begin
      nextCycle;
      idx = (cycleCount / 4) % 6;
      checkOutput({tag, "_sel"}, 32'(digitSel), 32'(6'b000001 << idx));
      checkOutput({tag, "_val"}, 32'(digitVal), 32'(digits[idx*4 +: 4]));
      checkOutput({tag, "_blank"}, 32'(blank), 32'((idx == 5) && expBlank1));
      checkOutput({tag, "_sel2"}, 32'(digitSel2), 32'(6'b000001 << idx));
      checkOutput({tag, "_val2"}, 32'(digitVal2), 32'(digits[idx*4 +: 4]));
      checkOutput({tag, "_blank2"}, 32'(blank2), 32'((idx == 5) && expBlank2));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_upd"}, 32'(updDone), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; sec = 6'd0; min = 6'd0; hr = 6'd0;

    // Reset held with clock running
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstSel", 32'(digitSel), 32'h01);
    checkOutput("rstVal", 32'(digitVal), 32'd0);
    checkOutput("rstBlank", 32'(blank), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstUpd", 32'(updDone), 32'd0);
    checkOutput("rstConv", 32'(convBin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scanCheck("idle", 24'h000000, 1'b1, 1'b0);

    // Single update 23:07:45
    @(posedge clk);
    #1;
    applyStimulus(6'd45, 6'd7, 6'd23);
    scanCheck("single", 24'h230745, 1'b0, 1'b0);

    // Extra ticks during CONV_M and at the CONV_H edge collapse into one rerun
    updStart = updCount;
    sec = 6'd30; min = 6'd20; hr = 6'd10; tick = 1'b1;
    nextCycle;
    tick = 1'b0;
    checkOutput("colSec", 32'(convBin), 32'd30);
    nextCycle;
    checkOutput("colMin", 32'(convBin), 32'd20);
    tick = 1'b1; sec = 6'd12;
    nextCycle;
    checkOutput("colHr", 32'(convBin), 32'd10);
    nextCycle;
    tick = 1'b0;
    checkOutput("colUpd1", 32'(updDone), 32'd1);
    checkOutput("colBusy", 32'(busy), 32'd1);
    checkOutput("colSec2", 32'(convBin), 32'd12);
    nextCycle;
    checkOutput("colMin2", 32'(convBin), 32'd20);
    checkOutput("colUpdGap", 32'(updDone), 32'd0);
    nextCycle;
    checkOutput("colHr2", 32'(convBin), 32'd10);
    nextCycle;
    checkOutput("colUpd2", 32'(updDone), 32'd1);
    checkOutput("colIdle", 32'(busy), 32'd0);
    repeat (4) nextCycle;
    checkOutput("colBusyAfter", 32'(busy), 32'd0);
    checkOutput("colUpdCount", 32'(updCount - updStart), 32'd2);
    scanCheck("collapse", 24'h102012, 1'b0, 1'b0);

    // Leading hours zero blanking
    applyStimulus(6'd0, 6'd0, 6'd5);
    scanCheck("blank5", 24'h050000, 1'b1, 1'b0);
    applyStimulus(6'd0, 6'd0, 6'd15);
    scanCheck("blank15", 24'h150000, 1'b0, 1'b0);

    // Asynchronous reset during CONV_M with a pending request
    sec = 6'd59; min = 6'd58; hr = 6'd57; tick = 1'b1;
    nextCycle;
    nextCycle;
    tick = 1'b0;
    checkOutput("midBusy", 32'(busy), 32'd1);
    checkOutput("midConv", 32'(convBin), 32'd58);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", 32'(busy), 32'd0);
    checkOutput("asyncConv", 32'(convBin), 32'd0);
    checkOutput("asyncSel", 32'(digitSel), 32'h01);
    checkOutput("asyncVal", 32'(digitVal), 32'd0);
    checkOutput("asyncUpd", 32'(updDone), 32'd0);
    checkOutput("asyncBlank", 32'(blank), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    scanCheck("postRst", 24'h000000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
